// File: rtl/bullet_hit_detector_if.sv
// Hit delivery channel from the hit detector to the enemy manager.
// valid/ready: a hit transfers on every clock where hit_valid && hit_ready;
// the producer holds hit_col/hit_row stable while hit_valid && !hit_ready,
// and hit_valid never depends combinationally on hit_ready.
interface bullet_hit_detector_if;
    logic        hit_valid;
    logic        hit_ready;
    logic [11:0] hit_col;
    logic [10:0] hit_row;

    modport master (output hit_valid, output hit_col, output hit_row, input hit_ready);
    modport slave  (input hit_valid, input hit_col, input hit_row, output hit_ready);
endinterface

// File: rtl/bullet_hit_detector.sv
// Bullet/enemy pixel coincidence detector. During the display scan each
// overlapping pixel is queued as a (row, col) hit and counted in a saturating
// score; during the calc phase queued hits drain over the hit channel.
module bullet_hit_detector #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int SCORE_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               hardReset,
    input  logic               calc,
    input  logic [24:0]        bullet_color,
    input  logic               enemy_pixel,
    input  logic [11:0]        display_col,
    input  logic [10:0]        display_row,
    bullet_hit_detector_if.master hit_if,
    output logic [SCORE_W-1:0] score,
    output logic               hit_overflow,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_SCAN  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    state_e               state_q, state_d;
    logic [11:0]          col_d_q;
    logic [10:0]          row_d_q;
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 ovf_q, ovf_d;
    logic [22:0]          mem_q [DEPTH];

    logic                 hit;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 drop;
    logic                 pop;
    logic                 valid;
    logic [22:0]          head;

    // Colour bits are carried by the renderer but irrelevant to hit detection.
    logic                 unused_color;
    assign unused_color = ^bullet_color[24:1];

    // Hit qualification, FIFO status and handshake, all from registered state.
    always_comb begin
        hit        = bullet_color[0] & enemy_pixel;
        fifo_full  = (count_q == FULL_CNT);
        fifo_empty = (count_q == '0);
        push       = (state_q == ST_SCAN) && hit && !fifo_full;
        drop       = (state_q == ST_SCAN) && hit && fifo_full;
        valid      = (state_q == ST_DRAIN) && !fifo_empty;
        pop        = valid && hit_if.hit_ready;
        head       = mem_q[rd_ptr_q];
    end

    // Next-state for the phase FSM, FIFO pointers, score and overflow flag.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        score_d  = score_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_SCAN: begin
                if (calc) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leaving early keeps undelivered hits for the next frame.
                if (!calc) begin
                    state_d = ST_SCAN;
                    ovf_d   = 1'b0;
                end else if (fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!calc) begin
                    state_d = ST_SCAN;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_SCAN;
        endcase

        // Push (SCAN only) and pop (DRAIN only) are mutually exclusive.
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            count_d  = count_q + (ADDR_W + 1)'(1);
            if (score_q != '1) score_d = score_q + SCORE_W'(1);
        end
        if (drop) ovf_d = 1'b1;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            count_d  = count_q - (ADDR_W + 1)'(1);
        end

        // Game restart wins over everything except reset.
        if (hardReset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            score_d  = '0;
            ovf_d    = 1'b0;
            state_d  = calc ? ST_DONE : ST_SCAN;
        end
    end

    // State and control registers, plus the one-cycle coordinate delay that
    // lines scan position up with the registered renderer output.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_SCAN;
            col_d_q  <= '0;
            row_d_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            score_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_d_q  <= display_col;
            row_d_q  <= display_row;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            score_q  <= score_d;
            ovf_q    <= ovf_d;
        end
    end

    // Hit storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= {row_d_q, col_d_q};
    end

    // Head is masked to zero when empty so coordinates read 0 out of reset.
    assign hit_if.hit_valid = valid;
    assign hit_if.hit_col   = fifo_empty ? 12'd0 : head[11:0];
    assign hit_if.hit_row   = fifo_empty ? 11'd0 : head[22:12];
    assign score            = score_q;
    assign hit_overflow     = ovf_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_bullet_hit_detector.sv
// Directed bench for bullet_hit_detector: reset, in-order drain, stall,
// overflow, non-hit pixels and mid-drain game restart.
module tb_bullet_hit_detector;

    localparam logic [1:0] S_SCAN  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic        clock = 1'b0;
    logic        reset;
    logic        hardReset;
    logic        calc;
    logic [24:0] bullet_color;
    logic        enemy_pixel;
    logic [11:0] display_col;
    logic [10:0] display_row;
    logic [15:0] score;
    logic        hit_overflow;
    logic [1:0]  dbg_state;

    int n_vec  = 0;
    int n_miss = 0;

    bullet_hit_detector_if hif ();

    bullet_hit_detector #(.DEPTH(16), .ADDR_W(4), .SCORE_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .hardReset    (hardReset),
        .calc         (calc),
        .bullet_color (bullet_color),
        .enemy_pixel  (enemy_pixel),
        .display_col  (display_col),
        .display_row  (display_row),
        .hit_if       (hif),
        .score        (score),
        .hit_overflow (hit_overflow),
        .dbg_state    (dbg_state)
    );

    // Clock and a hard time limit.
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a coordinate, then assert the hit one cycle later.
    task automatic push_hit(input logic [11:0] c, input logic [10:0] r);
        display_col  = c;
        display_row  = r;
        bullet_color = '0;
        enemy_pixel  = 1'b0;
        tick();
        bullet_color = {24'($urandom), 1'b1};
        enemy_pixel  = 1'b1;
        display_col  = c + 12'd1;
        display_row  = r + 11'd1;
        tick();
        bullet_color = '0;
        enemy_pixel  = 1'b0;
    endtask

    task automatic do_hard_reset();
        calc      = 1'b0;
        hardReset = 1'b1;
        tick();
        hardReset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hardReset    = 1'($urandom);
            calc         = 1'($urandom);
            bullet_color = 25'($urandom);
            enemy_pixel  = 1'($urandom);
            display_col  = 12'($urandom);
            display_row  = 11'($urandom);
            hif.hit_ready = 1'($urandom);
            tick();
            n_vec++; if (hif.hit_valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid: got %0b want 0", hif.hit_valid); end
            n_vec++; if (score !== 16'd0) begin n_miss++; $display("FAIL reset_score: got %0d want 0", score); end
            n_vec++; if (hit_overflow !== 1'b0) begin n_miss++; $display("FAIL reset_ovf: got %0b want 0", hit_overflow); end
            n_vec++; if (hif.hit_col !== 12'd0 || hif.hit_row !== 11'd0) begin n_miss++; $display("FAIL reset_coord: got (%0d,%0d) want (0,0)", hif.hit_col, hif.hit_row); end
        end
        hardReset = 1'b0; calc = 1'b0; bullet_color = '0; enemy_pixel = 1'b0;
        display_col = '0; display_row = '0; hif.hit_ready = 1'b0;
        reset = 1'b0;
        tick();
        n_vec++; if (dbg_state !== S_SCAN) begin n_miss++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_SCAN); end
    endtask

    task automatic test_drain();
        logic [11:0] cols [3];
        logic [10:0] rows [3];
        cols = '{12'd100, 12'd200, 12'd300};
        rows = '{11'd50, 11'd60, 11'd70};
        do_hard_reset();
        for (int i = 0; i < 3; i++) push_hit(cols[i], rows[i]);
        n_vec++; if (hif.hit_valid !== 1'b0) begin n_miss++; $display("FAIL drain_valid_in_scan: got %0b want 0", hif.hit_valid); end
        calc = 1'b1; hif.hit_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (hif.hit_valid !== 1'b1) begin n_miss++; $display("FAIL drain_valid[%0d]: got %0b want 1", i, hif.hit_valid); end
            n_vec++; if (hif.hit_col !== cols[i] || hif.hit_row !== rows[i]) begin n_miss++; $display("FAIL drain_coord[%0d]: got (%0d,%0d) want (%0d,%0d)", i, hif.hit_col, hif.hit_row, cols[i], rows[i]); end
            tick();
        end
        n_vec++; if (hif.hit_valid !== 1'b0) begin n_miss++; $display("FAIL drain_valid_empty: got %0b want 0", hif.hit_valid); end
        n_vec++; if (score !== 16'd3) begin n_miss++; $display("FAIL drain_score: got %0d want 3", score); end
        tick();
        n_vec++; if (dbg_state !== S_DONE) begin n_miss++; $display("FAIL drain_state_done: got %0d want %0d", dbg_state, S_DONE); end
        tick();
        n_vec++; if (hif.hit_valid !== 1'b0) begin n_miss++; $display("FAIL drain_valid_done: got %0b want 0", hif.hit_valid); end
        calc = 1'b0;
        tick();
        n_vec++; if (dbg_state !== S_SCAN) begin n_miss++; $display("FAIL drain_state_scan: got %0d want %0d", dbg_state, S_SCAN); end
    endtask

    task automatic test_stall();
        logic [11:0] cols [3];
        logic [10:0] rows [3];
        cols = '{12'd100, 12'd200, 12'd300};
        rows = '{11'd50, 11'd60, 11'd70};
        do_hard_reset();
        for (int i = 0; i < 3; i++) push_hit(cols[i], rows[i]);
        calc = 1'b1; hif.hit_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (hif.hit_valid !== 1'b1) begin n_miss++; $display("FAIL stall_valid[%0d]: got %0b want 1", i, hif.hit_valid); end
            n_vec++; if (hif.hit_col !== 12'd100 || hif.hit_row !== 11'd50) begin n_miss++; $display("FAIL stall_hold[%0d]: got (%0d,%0d) want (100,50)", i, hif.hit_col, hif.hit_row); end
            tick();
        end
        hif.hit_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (hif.hit_valid !== 1'b1 || hif.hit_col !== cols[i] || hif.hit_row !== rows[i]) begin n_miss++; $display("FAIL stall_release[%0d]: got v=%0b (%0d,%0d) want v=1 (%0d,%0d)", i, hif.hit_valid, hif.hit_col, hif.hit_row, cols[i], rows[i]); end
            tick();
        end
        n_vec++; if (hif.hit_valid !== 1'b0) begin n_miss++; $display("FAIL stall_empty: got %0b want 0", hif.hit_valid); end
        tick();
        calc = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        logic [11:0] c;
        logic [10:0] r;
        do_hard_reset();
        for (int i = 0; i < 17; i++) push_hit(12'(10 * i + 5), 11'(i + 1));
        n_vec++; if (hit_overflow !== 1'b1) begin n_miss++; $display("FAIL ovf_set: got %0b want 1", hit_overflow); end
        n_vec++; if (score !== 16'd16) begin n_miss++; $display("FAIL ovf_score: got %0d want 16", score); end
        calc = 1'b1; hif.hit_ready = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            c = 12'(10 * i + 5);
            r = 11'(i + 1);
            n_vec++; if (hif.hit_valid !== 1'b1 || hif.hit_col !== c || hif.hit_row !== r) begin n_miss++; $display("FAIL ovf_drain[%0d]: got v=%0b (%0d,%0d) want v=1 (%0d,%0d)", i, hif.hit_valid, hif.hit_col, hif.hit_row, c, r); end
            tick();
        end
        n_vec++; if (hif.hit_valid !== 1'b0) begin n_miss++; $display("FAIL ovf_no_17th: got %0b want 0", hif.hit_valid); end
        tick();
        n_vec++; if (hit_overflow !== 1'b1) begin n_miss++; $display("FAIL ovf_sticky_done: got %0b want 1", hit_overflow); end
        calc = 1'b0;
        tick();
        n_vec++; if (hit_overflow !== 1'b0) begin n_miss++; $display("FAIL ovf_clear: got %0b want 0", hit_overflow); end
    endtask

    task automatic test_no_hit();
        for (int i = 0; i < 100; i++) begin
            display_col  = 12'(i * 3);
            display_row  = 11'(i);
            bullet_color = (i < 50) ? {24'($urandom), 1'b1} : {24'($urandom), 1'b0};
            enemy_pixel  = (i < 50) ? 1'b0 : 1'b1;
            tick();
        end
        bullet_color = '0; enemy_pixel = 1'b0;
        tick();
        n_vec++; if (score !== 16'd16) begin n_miss++; $display("FAIL nohit_score: got %0d want 16", score); end
        calc = 1'b1; hif.hit_ready = 1'b1;
        tick();
        n_vec++; if (hif.hit_valid !== 1'b0) begin n_miss++; $display("FAIL nohit_fifo_empty: got %0b want 0", hif.hit_valid); end
        tick();
        n_vec++; if (dbg_state !== S_DONE) begin n_miss++; $display("FAIL nohit_state: got %0d want %0d", dbg_state, S_DONE); end
        calc = 1'b0;
        tick();
    endtask

    task automatic test_hard_reset();
        do_hard_reset();
        for (int i = 0; i < 4; i++) push_hit(12'(400 + i), 11'(20 + i));
        n_vec++; if (score !== 16'd4) begin n_miss++; $display("FAIL hr_score_pre: got %0d want 4", score); end
        calc = 1'b1; hif.hit_ready = 1'b1;
        tick();
        n_vec++; if (hif.hit_valid !== 1'b1 || hif.hit_col !== 12'd400 || hif.hit_row !== 11'd20) begin n_miss++; $display("FAIL hr_first: got v=%0b (%0d,%0d) want v=1 (400,20)", hif.hit_valid, hif.hit_col, hif.hit_row); end
        tick();
        n_vec++; if (hif.hit_valid !== 1'b1 || hif.hit_col !== 12'd401 || hif.hit_row !== 11'd21) begin n_miss++; $display("FAIL hr_second: got v=%0b (%0d,%0d) want v=1 (401,21)", hif.hit_valid, hif.hit_col, hif.hit_row); end
        hardReset = 1'b1;
        tick();
        hardReset = 1'b0;
        n_vec++; if (hif.hit_valid !== 1'b0) begin n_miss++; $display("FAIL hr_valid: got %0b want 0", hif.hit_valid); end
        n_vec++; if (score !== 16'd0) begin n_miss++; $display("FAIL hr_score: got %0d want 0", score); end
        n_vec++; if (dbg_state !== S_DONE) begin n_miss++; $display("FAIL hr_state: got %0d want %0d", dbg_state, S_DONE); end
        tick();
        calc = 1'b0;
        tick();
        n_vec++; if (dbg_state !== S_SCAN) begin n_miss++; $display("FAIL hr_next_scan: got %0d want %0d", dbg_state, S_SCAN); end
        calc = 1'b1;
        tick();
        n_vec++; if (dbg_state !== S_DRAIN || hif.hit_valid !== 1'b0) begin n_miss++; $display("FAIL hr_next_drain: got st=%0d v=%0b want st=%0d v=0", dbg_state, hif.hit_valid, S_DRAIN); end
        tick();
        n_vec++; if (dbg_state !== S_DONE) begin n_miss++; $display("FAIL hr_next_done: got %0d want %0d", dbg_state, S_DONE); end
        calc = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_drain();
        test_stall();
        test_overflow();
        test_no_hit();
        test_hard_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
